// File: rtl/uart_tx_sched_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_if
// Bundle of the signals that connect the telemetry scheduler to its
// requesters and to the shared UART transmitter.
//
//   req      requester -> scheduler : level request, one bit per requester
//   payload  requester -> scheduler : PAYLOAD_BYTES bytes per requester
//   ack      scheduler -> requester : one-cycle "frame finished" pulse
//   busy     scheduler -> system    : high while a frame is in progress
//   trmt     scheduler -> UART_tx   : one-cycle start strobe
//   tx_data  scheduler -> UART_tx   : byte to transmit
//   tx_done  UART_tx   -> scheduler : byte-complete level
//
// modport slave  : the scheduler side
// modport master : the environment (requesters + transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int NUM_REQ       = 2,
    parameter int PAYLOAD_BYTES = 4
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] payload;
    logic [NUM_REQ-1:0]                 ack;
    logic                               busy;
    logic                               trmt;
    logic [7:0]                         tx_data;
    logic                               tx_done;

    modport master (
        output req, payload, tx_done,
        input  ack, busy, trmt, tx_data
    );

    modport slave (
        input  req, payload, tx_done,
        output ack, busy, trmt, tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmitter among NUM_REQ telemetry requesters. Requests
// are served round-robin; each granted payload is framed as
//   SYNC_BYTE, ID {6'b0, grant}, payload byte 0 .. PAYLOAD_BYTES-1 [, CKSUM]
// and handed to UART_tx one byte at a time via trmt/tx_done. The granted
// requester gets a one-cycle ack when its frame is complete.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (also resets UART_tx)
//   bus    uart_tx_sched_if.slave: req, payload, tx_done in; ack, busy,
//          trmt, tx_data out (all outputs registered)
//
// Build option:
//   TELEM_CKSUM_EN  when defined, appends CKSUM = XOR of the ID byte and all
//                   payload bytes as the final frame byte.
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int          NUM_REQ       = 2,
    parameter int          PAYLOAD_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_sched_if.slave   bus
);

    localparam int PAY_W = PAYLOAD_BYTES * 8;
`ifdef TELEM_CKSUM_EN
    localparam int         FRAME_LEN = PAYLOAD_BYTES + 3;
    localparam logic [4:0] CKSUM_IDX = 5'(PAYLOAD_BYTES + 2);
`else
    localparam int         FRAME_LEN = PAYLOAD_BYTES + 2;
`endif
    localparam logic [4:0]         LAST_IDX = 5'(FRAME_LEN - 1);
    localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic                r_trmt;
    logic [7:0]          r_txData;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_busy;
    logic [1:0]          r_rrPtr;
    logic [1:0]          r_grant;
    logic [4:0]          r_idx;
    logic [PAY_W-1:0]    r_shadow;
`ifdef TELEM_CKSUM_EN
    logic [7:0]          r_cksum;
`endif

    logic                w_anyReq;
    logic [1:0]          w_grantIdx;
    logic [PAY_W-1:0]    w_selPayload;
    logic [4:0]          w_nextIdx;
    logic [7:0]          w_nextByte;

    // Round-robin search: first set req bit starting at r_rrPtr, wrapping.
    always_comb begin
        w_anyReq   = 1'b0;
        w_grantIdx = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_anyReq && bus.req[(int'(r_rrPtr) + k) % NUM_REQ]) begin
                w_anyReq   = 1'b1;
                w_grantIdx = 2'((int'(r_rrPtr) + k) % NUM_REQ);
            end
        end
    end

    // Payload slice of the requester about to be granted.
    always_comb begin
        w_selPayload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantIdx == 2'(i)) begin
                w_selPayload = bus.payload[i*PAY_W +: PAY_W];
            end
        end
    end

    assign w_nextIdx = r_idx + 5'd1;

    // Frame byte at index r_idx+1. Index 0 (sync) is loaded directly on grant.
    always_comb begin
        w_nextByte = 8'h00;
        if (w_nextIdx == 5'd1) begin
            w_nextByte = {6'b0, r_grant};
        end
        for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            if (w_nextIdx == 5'(b + 2)) begin
                w_nextByte = r_shadow[b*8 +: 8];
            end
        end
`ifdef TELEM_CKSUM_EN
        if (w_nextIdx == CKSUM_IDX) begin
            w_nextByte = r_cksum;
        end
`endif
    end

    // Frame sequencer. trmt/ack are pulses that default low each cycle; the
    // byte and its strobe are loaded on the edge that enters SEND, so SEND
    // is exactly the cycle in which trmt is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_trmt   <= 1'b0;
            r_txData <= 8'h00;
            r_ack    <= '0;
            r_busy   <= 1'b0;
            r_rrPtr  <= 2'd0;
            r_grant  <= 2'd0;
            r_idx    <= 5'd0;
            r_shadow <= '0;
`ifdef TELEM_CKSUM_EN
            r_cksum  <= 8'h00;
`endif
        end else begin
            r_trmt <= 1'b0;
            r_ack  <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_grant  <= w_grantIdx;
                        r_shadow <= w_selPayload;
                        r_idx    <= 5'd0;
`ifdef TELEM_CKSUM_EN
                        r_cksum  <= 8'h00;
`endif
                        r_txData <= SYNC_BYTE;
                        r_trmt   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_ack   <= ACK_ONE << r_grant;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx    <= w_nextIdx;
                            r_txData <= w_nextByte;
                            r_trmt   <= 1'b1;
`ifdef TELEM_CKSUM_EN
                            // Fold ID and payload bytes in as they are loaded.
                            if (w_nextIdx != CKSUM_IDX) begin
                                r_cksum <= r_cksum ^ w_nextByte;
                            end
`endif
                            r_state  <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    if (int'(r_grant) >= NUM_REQ - 1) begin
                        r_rrPtr <= 2'd0;
                    end else begin
                        r_rrPtr <= r_grant + 2'd1;
                    end
                    r_idx   <= 5'd0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trmt    = r_trmt;
    assign bus.tx_data = r_txData;
    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched with default parameters. A
// behavioural transmitter answers each trmt with tx_done after a random
// delay and logs every byte; expected frames and grant order are built from
// the framing and round-robin rules. Honours TELEM_CKSUM_EN like the design.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int         NR   = 2;
    localparam int         PB   = 4;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef TELEM_CKSUM_EN
    localparam int FL = PB + 3;
`else
    localparam int FL = PB + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NR), .PAYLOAD_BYTES(PB)) bus ();

    uart_tx_sched #(
        .NUM_REQ       (NR),
        .PAYLOAD_BYTES (PB),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0]    byteQ[$];
    int            trmtCycQ[$];
    int            doneCycQ[$];
    logic [NR-1:0] ackQ[$];
    int            ackCycQ[$];
    logic [7:0]    expQ[$];
    logic [NR-1:0] expAckQ[$];
    int            rrModel;

    // Behavioural UART_tx plus output logger, sampling 1 time unit after
    // each rising edge. tx_done clears on trmt and sets 1..5 cycles later.
    initial begin
        int cnt;
        cnt = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                bus.tx_done = 1'b0;
                cnt = 0;
            end else begin
                if (bus.trmt) begin
                    vectors++;
                    if (cnt != 0) begin
                        miscompares++;
                        $display("[TB] FAIL trmt_before_done: trmt=1 at cycle %0d with byte pending, required trmt=0", cyc);
                    end
                    vectors++;
                    if (bus.busy !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL busy_in_frame: busy=%b at trmt, required 1", bus.busy);
                    end
                    byteQ.push_back(bus.tx_data);
                    trmtCycQ.push_back(cyc);
                    bus.tx_done = 1'b0;
                    cnt = $urandom_range(1, 5);
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.tx_done = 1'b1;
                        doneCycQ.push_back(cyc);
                    end
                end
                if (bus.ack != '0) begin
                    ackQ.push_back(bus.ack);
                    ackCycQ.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearLogs();
        byteQ.delete();
        trmtCycQ.delete();
        doneCycQ.delete();
        ackQ.delete();
        ackCycQ.delete();
        expQ.delete();
        expAckQ.delete();
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        clearLogs();
        rrModel = 0;
    endtask

    task automatic setPayload(input int i, input logic [PB*8-1:0] v);
        bus.payload[i*PB*8 +: PB*8] = v;
    endtask

    // Expected frame for requester g carrying payload pay.
    task automatic buildFrame(input int g, input logic [PB*8-1:0] pay);
        logic [7:0] id;
        logic [7:0] cks;
        id  = 8'(g);
        cks = id;
        expQ.push_back(SYNC);
        expQ.push_back(id);
        for (int k = 0; k < PB; k++) begin
            expQ.push_back(pay[8*k +: 8]);
            cks = cks ^ pay[8*k +: 8];
        end
`ifdef TELEM_CKSUM_EN
        expQ.push_back(cks);
`endif
    endtask

    // Runs cycles until nAcks acks seen; a requester drops req in the ack
    // cycle and, with reassert, raises it again one cycle later. All req
    // bits drop after the final ack.
    task automatic runUntilAcks(input int nAcks, input bit reassert, input int budget,
                                output bit timedOut);
        int            got;
        logic [NR-1:0] dropped;
        got     = 0;
        dropped = '0;
        for (int c = 0; c < budget && got < nAcks; c++) begin
            @(posedge clk);
            #2;
            if (dropped != '0) begin
                bus.req = bus.req | dropped;
                dropped = '0;
            end
            if (bus.ack != '0) begin
                bus.req = bus.req & ~bus.ack;
                got++;
                if (got >= nAcks) bus.req = '0;
                else if (reassert) dropped = bus.ack;
            end
        end
        timedOut = (got < nAcks);
    endtask

    task automatic test_reset();
        doReset();
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            vectors++;
            if ({bus.trmt, bus.busy, bus.ack, bus.tx_data} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle: trmt=%b busy=%b ack=%b tx_data=%h, required all 0",
                         bus.trmt, bus.busy, bus.ack, bus.tx_data);
            end
        end
        vectors++;
        if (byteQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_bytes: %0d bytes sent, required 0", byteQ.size());
        end
    endtask

    task automatic test_single_frame(input int g, input logic [PB*8-1:0] pay);
        bit            to;
        int            reqCyc;
        int            first;
        int            nBytes;
        logic [NR-1:0] one;
        doReset();
        setPayload(g, pay);
        setPayload(1 - g, 32'($urandom));
        buildFrame(g, pay);
        one     = 1;
        reqCyc  = cyc;
        bus.req = one << g;
        runUntilAcks(1, 1'b0, 300, to);
        @(posedge clk);
        #2;
        vectors++;
        if (to) begin
            miscompares++;
            $display("[TB] FAIL single_timeout: no ack within budget, required ack");
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_busy_after: busy=%b, required 0", bus.busy);
        end
        repeat (5) @(posedge clk);
        #2;
        vectors++;
        if (byteQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL single_len: %0d bytes, required %0d", byteQ.size(), expQ.size());
        end
        for (int k = 0; k < expQ.size() && k < byteQ.size(); k++) begin
            vectors++;
            if (byteQ[k] !== expQ[k]) begin
                miscompares++;
                $display("[TB] FAIL single_byte%0d: got %h, required %h", k, byteQ[k], expQ[k]);
            end
        end
        vectors++;
        if (ackQ.size() != 1 || ackQ[0] !== (one << g)) begin
            miscompares++;
            $display("[TB] FAIL single_ack: %0d acks first=%b, required 1 ack %b",
                     ackQ.size(), (ackQ.size() > 0) ? ackQ[0] : '0, one << g);
        end
        first = (trmtCycQ.size() > 0) ? trmtCycQ[0] : -1;
        vectors++;
        if (first != reqCyc + 1) begin
            miscompares++;
            $display("[TB] FAIL req_to_trmt: trmt at cycle %0d, required %0d", first, reqCyc + 1);
        end
        nBytes = trmtCycQ.size();
        for (int k = 1; k < FL && k < nBytes && k - 1 < doneCycQ.size(); k++) begin
            vectors++;
            if (trmtCycQ[k] != doneCycQ[k-1] + 1) begin
                miscompares++;
                $display("[TB] FAIL done_to_trmt%0d: trmt at %0d, required %0d",
                         k, trmtCycQ[k], doneCycQ[k-1] + 1);
            end
        end
        if (doneCycQ.size() >= FL && ackCycQ.size() >= 1) begin
            vectors++;
            if (ackCycQ[0] != doneCycQ[FL-1] + 1) begin
                miscompares++;
                $display("[TB] FAIL done_to_ack: ack at %0d, required %0d",
                         ackCycQ[0], doneCycQ[FL-1] + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        bit            to;
        logic [31:0]   p0;
        logic [31:0]   p1;
        logic [NR-1:0] want;
        doReset();
        p0 = $urandom;
        p1 = $urandom;
        setPayload(0, p0);
        setPayload(1, p1);
        for (int f = 0; f < 4; f++) begin
            buildFrame(f % 2, (f % 2 == 0) ? p0 : p1);
        end
        bus.req = 2'b11;
        runUntilAcks(4, 1'b1, 2000, to);
        repeat (5) @(posedge clk);
        #2;
        vectors++;
        if (to || ackQ.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL rr_ack_count: %0d acks, required 4", ackQ.size());
        end
        for (int k = 0; k < 4 && k < ackQ.size(); k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (ackQ[k] !== want) begin
                miscompares++;
                $display("[TB] FAIL rr_ack%0d: got %b, required %b", k, ackQ[k], want);
            end
        end
        vectors++;
        if (byteQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL rr_len: %0d bytes, required %0d", byteQ.size(), expQ.size());
        end
        for (int k = 0; k < expQ.size() && k < byteQ.size(); k++) begin
            vectors++;
            if (byteQ[k] !== expQ[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_byte%0d: got %h, required %h", k, byteQ[k], expQ[k]);
            end
        end
        for (int k = 0; k < 3 && k < ackCycQ.size() && (k + 1) * FL < trmtCycQ.size(); k++) begin
            vectors++;
            if (trmtCycQ[(k+1)*FL] != ackCycQ[k] + 2) begin
                miscompares++;
                $display("[TB] FAIL ack_to_trmt%0d: trmt at %0d, required %0d",
                         k, trmtCycQ[(k+1)*FL], ackCycQ[k] + 2);
            end
        end
    endtask

    task automatic test_payload_change();
        bit to;
        bit seen;
        doReset();
        setPayload(0, 32'hDEADBEEF);
        setPayload(1, 32'($urandom));
        buildFrame(0, 32'hDEADBEEF);
        bus.req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk);
            #2;
            seen = (byteQ.size() >= 1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL shadow_sync_timeout: no trmt seen, required sync trmt");
        end
        @(posedge clk);
        #2;
        setPayload(0, 32'h0);
        runUntilAcks(1, 1'b0, 300, to);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (to || byteQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL shadow_len: %0d bytes, required %0d", byteQ.size(), expQ.size());
        end
        for (int k = 0; k < expQ.size() && k < byteQ.size(); k++) begin
            vectors++;
            if (byteQ[k] !== expQ[k]) begin
                miscompares++;
                $display("[TB] FAIL shadow_byte%0d: got %h, required %h", k, byteQ[k], expQ[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit          to;
        bit          seen;
        logic [31:0] pay;
        doReset();
        pay = $urandom;
        setPayload(0, pay);
        setPayload(1, 32'($urandom));
        bus.req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #2;
            seen = (byteQ.size() >= 3);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL abort_timeout: %0d bytes, required 3 before reset", byteQ.size());
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.trmt, bus.busy, bus.ack, bus.tx_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: trmt=%b busy=%b ack=%b tx_data=%h, required all 0",
                     bus.trmt, bus.busy, bus.ack, bus.tx_data);
        end
        vectors++;
        if (ackQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_early_ack: %0d acks, required 0", ackQ.size());
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clearLogs();
        buildFrame(0, pay);
        runUntilAcks(1, 1'b0, 300, to);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (to || ackQ.size() != 1 || ackQ[0] !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL abort_ack: %0d acks, required one ack 01", ackQ.size());
        end
        vectors++;
        if (byteQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL abort_len: %0d bytes, required %0d", byteQ.size(), expQ.size());
        end
        for (int k = 0; k < expQ.size() && k < byteQ.size(); k++) begin
            vectors++;
            if (byteQ[k] !== expQ[k]) begin
                miscompares++;
                $display("[TB] FAIL abort_byte%0d: got %h, required %h", k, byteQ[k], expQ[k]);
            end
        end
    endtask

    // Random request masks across several rounds without reset, so the
    // round-robin pointer carries over between rounds.
    task automatic test_random_rounds();
        bit            to;
        bit            found;
        int            g;
        int            p;
        logic [NR-1:0] mask;
        logic [NR-1:0] pend;
        logic [NR-1:0] one;
        logic [31:0]   pays [NR];
        doReset();
        one = 1;
        for (int r = 0; r < 8; r++) begin
            clearLogs();
            mask = NR'($urandom_range(1, 3));
            for (int i = 0; i < NR; i++) begin
                pays[i] = $urandom;
                setPayload(i, pays[i]);
            end
            pend = mask;
            while (pend != '0) begin
                found = 1'b0;
                g = 0;
                for (int k = 0; k < NR; k++) begin
                    p = (rrModel + k) % NR;
                    if (!found && pend[p]) begin
                        g = p;
                        found = 1'b1;
                    end
                end
                buildFrame(g, pays[g]);
                expAckQ.push_back(one << g);
                pend    = pend & ~(one << g);
                rrModel = (g + 1) % NR;
            end
            bus.req = mask;
            runUntilAcks($countones(mask), 1'b0, 1000, to);
            repeat (3) @(posedge clk);
            #2;
            vectors++;
            if (to || ackQ.size() != expAckQ.size()) begin
                miscompares++;
                $display("[TB] FAIL rnd%0d_ack_count: %0d acks, required %0d",
                         r, ackQ.size(), expAckQ.size());
            end
            for (int k = 0; k < expAckQ.size() && k < ackQ.size(); k++) begin
                vectors++;
                if (ackQ[k] !== expAckQ[k]) begin
                    miscompares++;
                    $display("[TB] FAIL rnd%0d_ack%0d: got %b, required %b", r, k, ackQ[k], expAckQ[k]);
                end
            end
            vectors++;
            if (byteQ.size() != expQ.size()) begin
                miscompares++;
                $display("[TB] FAIL rnd%0d_len: %0d bytes, required %0d", r, byteQ.size(), expQ.size());
            end
            for (int k = 0; k < expQ.size() && k < byteQ.size(); k++) begin
                vectors++;
                if (byteQ[k] !== expQ[k]) begin
                    miscompares++;
                    $display("[TB] FAIL rnd%0d_byte%0d: got %h, required %h", r, k, byteQ[k], expQ[k]);
                end
            end
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.payload = '0;
        rst_n       = 1'b0;
        test_reset();
        test_single_frame(1, 32'h44332211);
        for (int n = 0; n < 3; n++) begin
            test_single_frame(int'($urandom_range(0, 1)), 32'($urandom));
        end
        test_round_robin();
        test_payload_change();
        test_reset_mid_frame();
        test_random_rounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet scheduler that shares one `UART_tx` transmitter among several telemetry requesters. Each requester presents a fixed-length payload. The block arbitrates round-robin and frames the winning payload as sync, ID, payload bytes and an optional checksum. It sequences the bytes into `UART_tx` through the `trmt`/`tx_done` handshake and acknowledges the requester when its frame is complete. It sits between the segway telemetry sources and the UART transmitter.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 1..4.
- `PAYLOAD_BYTES`, default 4: payload bytes per frame; legal range 1..15.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: level request, one bit per requester; held high until the matching `ack`.
- `payload` input NUM_REQ*PAYLOAD_BYTES*8: requester i owns slice [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8]; byte 0 is the least significant byte of the slice.
- `ack` output NUM_REQ: one-cycle pulse on the granted requester's bit when its frame is finished.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `trmt` output 1: one-cycle start strobe to `UART_tx`.
- `tx_data` output 8: byte to `UART_tx`; registered and stable from `trmt` until the next `trmt`.
- `tx_done` input 1: level from `UART_tx`; set when a byte completes, cleared by the transmitter on `trmt`.

## Operation
- Frame order is SYNC_BYTE, then ID byte {6'b0, grant index}, then payload byte 0..PAYLOAD_BYTES-1, then CKSUM (only when the checksum is enabled).
- Frame length is 2+PAYLOAD_BYTES bytes, plus 1 when the checksum is enabled.
- The byte index counter is 5 bits wide and resets to 0 for each frame.
- FSM states:
  - IDLE: if any `req` bit is high, grant the first set bit found searching upward from `rr_ptr` with wrap. At the same edge, latch that requester's payload slice into the shadow register, latch the grant index, clear the checksum, and go to SEND.
  - SEND: drive `trmt`=1 for one cycle with `tx_data` = current frame byte, then go to WAIT.
  - WAIT: hold until `tx_done`=1. If the current byte is the last, go to DONE; otherwise increment the index and go to SEND.
  - DONE: `ack[grant]`=1 for this cycle, set `rr_ptr` = (grant+1) mod NUM_REQ, then go to IDLE.
- Arbitration:
  - `req` bits that rise during a frame are ignored until the next IDLE.
  - A requester must drop `req` at the edge where it samples `ack`. If `req` is still high in the following IDLE, it is treated as a new request.
- The shadow register decouples the frame from `payload`; `payload` may change after grant.
- `tx_done` is sampled only in WAIT. Its level in IDLE is ignored; it is 0 after reset.
- Reset values: state IDLE, `trmt` 0, `tx_data` 8'h00, `ack` 0, `busy` 0, `rr_ptr` 0, index 0, checksum 0.
- Reset mid-frame aborts the frame immediately. No `ack` is issued and the requester keeps `req` high to be re-served. `UART_tx` shares `rst_n`, so it aborts too.
- With NUM_REQ=1, `rr_ptr` stays 0.

## Timing
- `req` seen high in IDLE at cycle t gives `trmt` at cycle t+1.
- `tx_done` seen in WAIT at cycle w gives either the next `trmt` at w+1, or `ack` at w+1 for the last byte.
- `ack` at cycle d: the earliest next grant is evaluated in IDLE at d+1, and the next `trmt` comes at d+2.
- Per-byte overhead on top of UART byte time is 2 cycles (SEND plus the WAIT exit).
- `trmt` is never asserted twice without an intervening `tx_done`=1 in WAIT.

## Configuration
- Macro: `TELEM_CKSUM_EN`.
- Defined:
  - CKSUM = XOR of the ID byte and all payload bytes.
  - It is accumulated as each byte is loaded into `tx_data` and appended as the final byte.
  - Frame length is 3+PAYLOAD_BYTES.
- Undefined: the checksum register and logic are removed, and the frame ends after the last payload byte.

## Test plan
- Reset, no `req` for 100 cycles -> `trmt`, `ack` and `busy` stay 0; `tx_data` stays 8'h00.
- Default parameters, checksum enabled, `req`=2'b10 with requester 1 payload 32'h44332211, real `UART_tx` attached -> decoded bytes A5,01,11,22,33,44,45; then one `ack`=2'b10 pulse.
- Same stimulus with the checksum disabled -> bytes A5,01,11,22,33,44 only; `ack` follows the 6th `tx_done`.
- `req`=2'b11 held continuously, with each requester dropping `req` for one cycle after its `ack` and then reasserting -> frames alternate ID 00,01,00,01; no requester is served twice in a row.
- Change requester 0's `payload` from 32'hDEADBEEF to 32'h0 one cycle after `trmt` of SYNC -> transmitted payload is still EF,BE,AD,DE.
- Assert `rst_n` low during the 3rd byte's WAIT with `req`=2'b01 held high -> outputs return to reset values; after release the full frame restarts from A5 with no earlier `ack`.
